// File: rtl/cpu_types_pkg.sv
// Shared types for the fetch stage.
//   fstate_t     : fetch FSM state (RUN, HOLD, HALTED)
//   if_id_t      : IF/ID pipeline register contents {valid, instr, pc, npc}
//   IF_ID_BUBBLE : all-zero, invalid IF/ID entry
//   make_if_id() : builds a valid entry with npc = pc + 4 (modulo 2^32)
package cpu_types_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } fstate_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] npc;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{valid: 1'b0, instr: 32'h0, pc: 32'h0, npc: 32'h0};

    function automatic if_id_t make_if_id(input logic [31:0] instr, input logic [31:0] pc);
        if_id_t e;
        e.valid = 1'b1;
        e.instr = instr;
        e.pc    = pc;
        e.npc   = pc + 32'd4;
        return e;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and its environment (I-cache, hazard
// unit, execute redirect, decode).
//   master : the fetch stage side (drives imem request and IF/ID outputs)
//   slave  : the environment side
// Signals: stall, flush, pc_mux, target_pc, halt, ihit, imemload (into fetch);
//          imemREN, imemaddr, id_valid, id_instr, id_pc, id_npc, fstate (out).
interface fetch_stage_if;
    import cpu_types_pkg::*;

    logic        stall;
    logic        flush;
    logic        pc_mux;
    logic [31:0] target_pc;
    logic        halt;
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_npc;
    fstate_t     fstate;

    modport master (
        input  stall, flush, pc_mux, target_pc, halt, ihit, imemload,
        output imemREN, imemaddr, id_valid, id_instr, id_pc, id_npc, fstate
    );

    modport slave (
        output stall, flush, pc_mux, target_pc, halt, ihit, imemload,
        input  imemREN, imemaddr, id_valid, id_instr, id_pc, id_npc, fstate
    );

endinterface

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register with its next-PC mux.
//   CLK, RST : clock, synchronous active-high reset (PC <= PC_INIT)
//   load     : take the redirect target (word aligned)
//   inc      : advance to PC + 4 (ignored when load is set)
//   target   : redirect address, bits [1:0] dropped
//   pc       : current PC
//   pc_plus4 : PC + 4, wraps modulo 2^32
module fetch_stage_pc_reg #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        load,
    input  logic        inc,
    input  logic [31:0] target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    logic unused_target_lsbs;
    assign unused_target_lsbs = ^target[1:0];

    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc <= PC_INIT;
        end else if (load) begin
            pc <= {target[31:2], 2'b00};
        end else if (inc) begin
            pc <= pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register and a one-entry hold
// buffer that keeps an instruction returned during a stall so it is not
// refetched.
//   CLK, RST : clock, synchronous active-high reset
//   fbus     : fetch_stage_if.master (hazard controls, redirect, halt, I-cache
//              request/response, IF/ID outputs, fstate for observation)
// Per-cycle priority: RST > halt > pc_mux > flush > stall > normal.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic          CLK,
    input  logic          RST,
    fetch_stage_if.master fbus
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_load;
    logic        pc_inc;

    fstate_t fstate_q;
    if_id_t  if_id_q;
    if_id_t  hold_q;
    logic    ren_q;

    // The PC only moves on a redirect or when a word actually returns in RUN;
    // this covers the flush, stall-capture and normal fetch cases alike.
    always_comb begin
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        if (fstate_q != HALTED && !fbus.halt) begin
            pc_load = fbus.pc_mux;
            pc_inc  = !fbus.pc_mux && fstate_q == RUN && fbus.ihit;
        end
    end

    fetch_stage_pc_reg #(
        .PC_INIT (PC_INIT)
    ) u_pc_reg (
        .CLK      (CLK),
        .RST      (RST),
        .load     (pc_load),
        .inc      (pc_inc),
        .target   (fbus.target_pc),
        .pc       (pc),
        .pc_plus4 (pc_plus4)
    );

    // imemREN is registered: it is set for the state being entered, so it is
    // high exactly while fstate is RUN.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fstate_q <= RUN;
            if_id_q  <= IF_ID_BUBBLE;
            hold_q   <= IF_ID_BUBBLE;
            ren_q    <= 1'b1;
        end else if (fstate_q == HALTED) begin
            // Only reset leaves HALTED.
            ren_q <= 1'b0;
        end else if (fbus.halt) begin
            fstate_q <= HALTED;
            if_id_q  <= IF_ID_BUBBLE;
            hold_q   <= IF_ID_BUBBLE;
            ren_q    <= 1'b0;
        end else if (fbus.pc_mux) begin
            fstate_q <= RUN;
            if_id_q  <= IF_ID_BUBBLE;
            hold_q   <= IF_ID_BUBBLE;
            ren_q    <= 1'b1;
        end else if (fbus.flush) begin
            // Any word returning this cycle is dropped; PC still advances.
            if_id_q <= IF_ID_BUBBLE;
        end else if (fbus.stall) begin
            if (fstate_q == RUN && fbus.ihit) begin
                hold_q   <= make_if_id(fbus.imemload, pc);
                fstate_q <= HOLD;
                ren_q    <= 1'b0;
            end
        end else if (fstate_q == HOLD) begin
            if_id_q  <= hold_q;
            hold_q   <= IF_ID_BUBBLE;
            fstate_q <= RUN;
            ren_q    <= 1'b1;
        end else if (fbus.ihit) begin
            if_id_q <= make_if_id(fbus.imemload, pc);
        end else begin
            if_id_q <= IF_ID_BUBBLE;
        end
    end

    assign fbus.imemaddr = pc;
    assign fbus.imemREN  = ren_q;
    assign fbus.id_valid = if_id_q.valid;
    assign fbus.id_instr = if_id_q.instr;
    assign fbus.id_pc    = if_id_q.pc;
    assign fbus.id_npc   = if_id_q.npc;
    assign fbus.fstate   = fstate_q;

    logic unused_pc_plus4;
    assign unused_pc_plus4 = ^pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage (PC_INIT = 0x200). Inputs change and outputs
// are checked 1 time unit after each rising edge.
module tb_fetch_stage;
    import cpu_types_pkg::*;

    logic CLK;
    logic RST;
    int   n_checks = 0;
    int   n_errors = 0;

    fetch_stage_if fbus ();

    fetch_stage #(
        .PC_INIT (32'h0000_0200)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .fbus (fbus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_if(input string tag, input logic v, input logic [31:0] instr,
                            input logic [31:0] pc, input logic [31:0] npc);
        check({tag, " id_valid"}, {31'h0, fbus.id_valid}, {31'h0, v});
        check({tag, " id_instr"}, fbus.id_instr, instr);
        check({tag, " id_pc"}, fbus.id_pc, pc);
        check({tag, " id_npc"}, fbus.id_npc, npc);
    endtask

    task automatic check_fe(input string tag, input fstate_t st, input logic ren,
                            input logic [31:0] addr);
        check({tag, " fstate"}, 32'(fbus.fstate), 32'(st));
        check({tag, " imemREN"}, {31'h0, fbus.imemREN}, {31'h0, ren});
        check({tag, " imemaddr"}, fbus.imemaddr, addr);
    endtask

    initial begin
        RST            = 1'b1;
        fbus.stall     = 1'b0;
        fbus.flush     = 1'b0;
        fbus.pc_mux    = 1'b0;
        fbus.target_pc = 32'h0;
        fbus.halt      = 1'b0;
        fbus.ihit      = 1'b0;
        fbus.imemload  = 32'h0;

        // Reset state
        tick();
        check_fe("reset", RUN, 1'b1, 32'h200);
        check_if("reset", 1'b0, 32'h0, 32'h0, 32'h0);

        // Sequential fetch from 0x200
        RST = 1'b0;
        fbus.ihit = 1'b1;
        fbus.imemload = 32'hAAAA_0001;
        tick();
        check_fe("seq0", RUN, 1'b1, 32'h204);
        check_if("seq0", 1'b1, 32'hAAAA_0001, 32'h200, 32'h204);
        fbus.imemload = 32'hAAAA_0002;
        tick();
        check_fe("seq1", RUN, 1'b1, 32'h208);
        check_if("seq1", 1'b1, 32'hAAAA_0002, 32'h204, 32'h208);

        // Three miss cycles
        fbus.ihit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_fe("miss", RUN, 1'b1, 32'h208);
            check_if("miss", 1'b0, 32'h0, 32'h0, 32'h0);
        end
        fbus.ihit = 1'b1;
        fbus.imemload = 32'hAAAA_0003;
        tick();
        check_fe("after_miss", RUN, 1'b1, 32'h20C);
        check_if("after_miss", 1'b1, 32'hAAAA_0003, 32'h208, 32'h20C);

        // Redirect with same-cycle hit: hit dropped, target aligned
        fbus.pc_mux = 1'b1;
        fbus.target_pc = 32'h0000_0043;
        fbus.imemload = 32'hDEAD_BEEF;
        tick();
        check_fe("redir", RUN, 1'b1, 32'h40);
        check_if("redir", 1'b0, 32'h0, 32'h0, 32'h0);
        fbus.pc_mux = 1'b0;
        fbus.ihit = 1'b0;
        tick();
        check_if("redir+1", 1'b0, 32'h0, 32'h0, 32'h0);

        // Go to 0x10 and stall while the word returns
        fbus.pc_mux = 1'b1;
        fbus.target_pc = 32'h0000_0010;
        tick();
        check_fe("to10", RUN, 1'b1, 32'h10);
        fbus.pc_mux = 1'b0;
        fbus.stall = 1'b1;
        fbus.ihit = 1'b1;
        fbus.imemload = 32'h8C41_0004;
        tick();
        check_fe("stall0", HOLD, 1'b0, 32'h14);
        check_if("stall0", 1'b0, 32'h0, 32'h0, 32'h0);
        fbus.ihit = 1'b0;
        tick();
        check_fe("stall1", HOLD, 1'b0, 32'h14);
        fbus.stall = 1'b0;
        tick();
        check_fe("release", RUN, 1'b1, 32'h14);
        check_if("release", 1'b1, 32'h8C41_0004, 32'h10, 32'h14);
        fbus.ihit = 1'b1;
        fbus.imemload = 32'hAAAA_0004;
        tick();
        check_fe("resume", RUN, 1'b1, 32'h18);
        check_if("resume", 1'b1, 32'hAAAA_0004, 32'h14, 32'h18);

        // Redirect while in HOLD drops the held word
        fbus.stall = 1'b1;
        fbus.imemload = 32'hAAAA_0005;
        tick();
        check_fe("hold2", HOLD, 1'b0, 32'h1C);
        fbus.pc_mux = 1'b1;
        fbus.target_pc = 32'h0000_0043;
        fbus.ihit = 1'b0;
        tick();
        check_fe("hold_redir", RUN, 1'b1, 32'h40);
        check_if("hold_redir", 1'b0, 32'h0, 32'h0, 32'h0);
        fbus.pc_mux = 1'b0;
        fbus.stall = 1'b0;
        tick();
        check_fe("hold_dropped", RUN, 1'b1, 32'h40);
        check_if("hold_dropped", 1'b0, 32'h0, 32'h0, 32'h0);

        // Fill IF/ID, then halt together with redirect and stall
        fbus.ihit = 1'b1;
        fbus.imemload = 32'hAAAA_0006;
        tick();
        check_if("pre_halt", 1'b1, 32'hAAAA_0006, 32'h40, 32'h44);
        fbus.halt = 1'b1;
        fbus.pc_mux = 1'b1;
        fbus.target_pc = 32'h0000_0100;
        fbus.stall = 1'b1;
        tick();
        check_fe("halt", HALTED, 1'b0, 32'h44);
        check_if("halt", 1'b0, 32'h0, 32'h0, 32'h0);
        fbus.halt = 1'b0;
        fbus.stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_fe("halted", HALTED, 1'b0, 32'h44);
            check_if("halted", 1'b0, 32'h0, 32'h0, 32'h0);
        end
        fbus.pc_mux = 1'b0;
        RST = 1'b1;
        tick();
        check_fe("rst_halted", RUN, 1'b1, 32'h200);
        check_if("rst_halted", 1'b0, 32'h0, 32'h0, 32'h0);

        // PC wrap at the top of the address space
        RST = 1'b0;
        fbus.ihit = 1'b0;
        fbus.pc_mux = 1'b1;
        fbus.target_pc = 32'hFFFF_FFFC;
        tick();
        check_fe("to_top", RUN, 1'b1, 32'hFFFF_FFFC);
        fbus.pc_mux = 1'b0;
        fbus.ihit = 1'b1;
        fbus.imemload = 32'hAAAA_0007;
        tick();
        check_fe("wrap", RUN, 1'b1, 32'h0);
        check_if("wrap", 1'b1, 32'hAAAA_0007, 32'hFFFF_FFFC, 32'h0);

        // Flush: bubble, PC still advances on the hit
        fbus.flush = 1'b1;
        fbus.imemload = 32'hAAAA_0008;
        tick();
        check_fe("flush", RUN, 1'b1, 32'h4);
        check_if("flush", 1'b0, 32'h0, 32'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for one core. It owns the PC and drives the instruction-cache request. It presents the fetched instruction to decode and consumes the `stall`/`flush` outputs of the hazard unit together with the resolved redirect from execute. A one-entry hold buffer keeps an instruction that returns during a stall, so it is never refetched.

## Interface
Parameters:
- `PC_INIT`, default `32'h0000_0000`: reset PC. Core 1 is instantiated with `32'h0000_0200`.

Ports:
- `CLK`  in  1: clock; all state is updated on the rising edge.
- `RST`  in  1: synchronous, active-high reset.
- `stall`  in  1: hazard-unit load-use stall. Freezes PC and IF/ID.
- `flush`  in  1: hazard-unit flush. IF/ID becomes a bubble.
- `pc_mux`  in  1: redirect valid (taken branch or jump resolved downstream).
- `target_pc`  in  32: redirect address; bits [1:0] are ignored (treated as 0).
- `halt`  in  1: halt resolved downstream. Stops fetch permanently until reset.
- `ihit`  in  1: instruction-cache hit for `imemaddr` this cycle.
- `imemload`  in  32: instruction data, valid when `ihit`=1.
- `imemREN`  out  1: instruction read request.
- `imemaddr`  out  32: fetch address (the current PC).
- `id_valid`  out  1: IF/ID holds a real instruction.
- `id_instr`  out  32: IF/ID instruction; `32'h0` when the stage holds a bubble.
- `id_pc`  out  32: PC of `id_instr`.
- `id_npc`  out  32: `id_pc + 4`.

## Operation
- State machine `fstate`, one of three states:
  - RUN: fetching.
  - HOLD: an instruction has been captured during a stall.
  - HALTED.
- Outputs:
  - `imemaddr` = PC.
  - `imemREN` = 1 only in RUN.
- Priority per cycle, highest first: `RST` > `halt` > `pc_mux` > `flush` > `stall` > normal.
- Reset: PC=`PC_INIT`, IF/ID = bubble (`id_valid`=0, `id_instr`/`id_pc`/`id_npc`=0), hold buffer empty, `fstate`=RUN.
- `halt`:
  - `fstate` goes to HALTED, IF/ID becomes a bubble, PC is frozen and the hold buffer is cleared.
  - HALTED ignores every input except `RST`.
- `pc_mux`:
  - PC <= `{target_pc[31:2],2'b00}`, IF/ID becomes a bubble, the hold buffer is discarded and `fstate` goes to RUN.
  - Any `ihit` in the same cycle is dropped.
- `flush` without `pc_mux`:
  - IF/ID becomes a bubble.
  - PC advances only if `ihit`=1 in RUN. The fetched word is also dropped.
- `stall` (no flush, no redirect):
  - IF/ID and PC hold.
  - In RUN with `ihit`=1: capture `imemload` and the PC into the hold buffer, PC <= PC+4, `fstate` goes to HOLD.
- Normal case, RUN:
  - `ihit`=1: IF/ID <= {1, `imemload`, PC, PC+4} and PC <= PC+4.
  - `ihit`=0: IF/ID becomes a bubble and PC holds.
- Normal case, HOLD: IF/ID <= hold buffer (valid), buffer emptied, `fstate` goes to RUN. No cache request is made that cycle.
- Arithmetic: PC+4 is 32-bit modulo. `32'hFFFF_FFFC` wraps to 0 with no flag.

## Timing
- Fetch latency: an instruction appears on `id_*` on the edge after the cycle in which `ihit`=1.
- Redirect:
  - `imemaddr` shows `target_pc` one cycle after `pc_mux` is sampled.
  - The first target instruction reaches IF/ID no earlier than two cycles after `pc_mux`.
- Stall release from HOLD: the held instruction enters IF/ID on the first non-stall edge, with zero refetch.
- `RST` asserted mid-operation (including in HOLD or HALTED) returns all state to reset values on that edge.
- `imemaddr` changes only on clock edges. Because the outputs are registered, `imemREN` and `imemaddr` are glitch-free.

## Structure
- `fstate_t` enum (RUN, HOLD, HALTED) and the `if_id_t` struct {valid, instr, pc, npc} live in `cpu_types_pkg`.
- Optional sub-module `pc_reg`: the PC register with its next-PC mux.
- Hold buffer: a single `if_id_t` register inside `fetch_stage`.

## Test plan
- Reset with `PC_INIT`=`32'h200`, then `ihit`=1 every cycle:
  - `imemaddr` sequence is 200, 204, 208.
  - `id_pc` lags by one cycle.
  - `id_npc` = `id_pc`+4.
- `ihit` low for 3 cycles:
  - `imemaddr` holds.
  - `id_valid`=0 for 3 cycles.
  - The next `ihit` advances normally.
- `stall`=1 for 2 cycles while `ihit`=1 returns `32'h8C41_0004` at PC `0x10`:
  - `fstate`=HOLD and `imemREN`=0.
  - After `stall` drops, `id_instr`=`8C410004` and `id_pc`=`0x10` with no second request for `0x10`.
  - Fetch resumes at `0x14`.
- `pc_mux`=1 with `target_pc`=`32'h0000_0043` in the same cycle as `ihit`, and again while in HOLD:
  - PC=`0x40`.
  - IF/ID is a bubble.
  - The hold buffer is dropped.
- `halt`=1 together with `pc_mux` and `stall`:
  - HALTED, `imemREN`=0, PC frozen, `id_valid`=0 indefinitely.
  - `RST` then restores `PC_INIT`.
- PC=`32'hFFFF_FFFC` with `ihit`: next `imemaddr`=0.
